// File: rtl/alu_shift_seq_pkg.sv
// alu_shift_seq_pkg: shared mode codes and FSM state encodings for the shift sequencer
package alu_shift_seq_pkg;

    localparam logic [1:0] ALU_SH_LSR = 2'd0;
    localparam logic [1:0] ALU_SH_ROR = 2'd1;
    localparam logic [1:0] ALU_SH_RCR = 2'd2;
    localparam logic [1:0] ALU_SH_ASR = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_shift_cin_mux.sv
// alu_shift_cin_mux: selects the fill bit fed to the shift slice from the latched mode
//   mode     in  2  latched shift mode (LSR/ROR/RCR/ASR)
//   arg_lsb  in  1  operand register bit 0 (ROR fill)
//   arg_msb  in  1  operand register top bit (ASR fill)
//   carry    in  1  carry register (RCR fill)
//   cin      out 1  fill bit for the slice
module alu_shift_cin_mux
    import alu_shift_seq_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       arg_lsb,
    input  logic       arg_msb,
    input  logic       carry,
    output logic       cin
);

    always_comb begin
        cin = (mode == ALU_SH_ROR) ? arg_lsb :
              (mode == ALU_SH_RCR) ? carry   :
              (mode == ALU_SH_ASR) ? arg_msb : 1'b0;
    end

endmodule

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-step shift/rotate sequencer driving a single-step shift/swap slice
//   clk, reset (async, active-high)
//   start, mode, count, operand, carry_init : instruction request, latched in IDLE
//   arg_l, cin, fn_swap, outn               : to slice
//   bus_res, cout_in                        : from slice
//   result, carry, busy, done               : status to the microcode controller
// Build option: ALU_SHIFT_SWAP_SHORTCUT_EN enables a nibble-swap step that rotates
// by 4 in one cycle during ROR; final result/carry are unchanged, only latency shrinks.
module alu_shift_seq
    import alu_shift_seq_pkg::*;
#(
    parameter int CNT_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] operand,
    input  logic              carry_init,
    output logic [DATA_W-1:0] arg_l,
    output logic              cin,
    output logic              fn_swap,
    output logic              outn,
    input  logic [DATA_W-1:0] bus_res,
    input  logic              cout_in,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              busy,
    output logic              done
);

    logic [1:0]       state;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] rem_nx;

    alu_shift_cin_mux u_cin_mux (
        .mode    (mode_r),
        .arg_lsb (arg_l[0]),
        .arg_msb (arg_l[DATA_W-1]),
        .carry   (carry),
        .cin     (cin)
    );

    always_comb begin
`ifdef ALU_SHIFT_SWAP_SHORTCUT_EN
        fn_swap = (state == ST_RUN) && (mode_r == ALU_SH_ROR) && (remaining >= CNT_W'(4));
`else
        fn_swap = 1'b0;
`endif
        rem_nx  = remaining - (fn_swap ? CNT_W'(4) : CNT_W'(1));
        outn    = state != ST_RUN;
        busy    = state == ST_RUN;
        done    = state == ST_DONE;
        result  = arg_l;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_r    <= ALU_SH_LSR;
            remaining <= '0;
            arg_l     <= '0;
            carry     <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                arg_l     <= operand;
                carry     <= carry_init;
                mode_r    <= mode;
                remaining <= count;
                state     <= (count != '0) ? ST_RUN : ST_DONE;
            end
        end else if (state == ST_RUN) begin
            // After a nibble swap the last bit rotated out sits in the new MSB
            arg_l     <= bus_res;
            carry     <= fn_swap ? bus_res[DATA_W-1] : cout_in;
            remaining <= rem_nx;
            state     <= (rem_nx == '0) ? ST_DONE : ST_RUN;
        end else begin
            state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: directed check of alu_shift_seq looped back through a model of the shift/swap slice
module tb_alu_shift_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] count = 3'd0;
    logic [7:0] operand = 8'h00;
    logic       carry_init = 1'b0;
    logic [7:0] arg_l;
    logic       cin;
    logic       fn_swap;
    logic       outn;
    logic [7:0] bus_res;
    logic       cout_in;
    logic [7:0] result;
    logic       carry;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int busy_n;
    int outn_bad;
    int done_seen;

    always #5 clk = ~clk;

    // Single-step slice: nibble swap or 1-bit right shift with fill cin; bus idle when disabled
    assign bus_res = outn ? 8'h00 : (fn_swap ? {arg_l[3:0], arg_l[7:4]} : {cin, arg_l[7:1]});
    assign cout_in = arg_l[0];

    alu_shift_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .count      (count),
        .operand    (operand),
        .carry_init (carry_init),
        .arg_l      (arg_l),
        .cin        (cin),
        .fn_swap    (fn_swap),
        .outn       (outn),
        .bus_res    (bus_res),
        .cout_in    (cout_in),
        .result     (result),
        .carry      (carry),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, scramble inputs after start, measure latency and busy cycles,
    // then poke start during DONE and confirm it is not taken.
    task automatic run(input logic [1:0] m, input logic [2:0] c, input logic [7:0] op, input logic ci);
        @(negedge clk);
        mode = m; count = c; operand = op; carry_init = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~m; count = ~c; operand = ~op; carry_init = ~ci;
        lat = 0; busy_n = 0; outn_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (outn === busy) outn_bad++;
            if (done) break;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_in_done_ignored", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_result", result, 8'h00);
        chk("rst_carry", carry, 1'b0);
        chk("rst_outn", outn, 1'b1);
        chk("rst_swap", fn_swap, 1'b0);
        chk("rst_busy_done", {busy, done}, 2'b00);
        reset = 1'b0;

        run(2'd0, 3'd3, 8'h96, 1'b0);
        chk("lsr_latency", lat, 4);
        chk("lsr_result", result, 8'h12);
        chk("lsr_carry", carry, 1'b1);
        chk("lsr_outn", outn_bad, 0);

        run(2'd1, 3'd1, 8'h81, 1'b0);
        chk("ror1_result", result, 8'hC0);
        chk("ror1_carry", carry, 1'b1);

        run(2'd2, 3'd2, 8'h01, 1'b0);
        chk("rcr_result", result, 8'h80);
        chk("rcr_carry", carry, 1'b0);

        run(2'd3, 3'd7, 8'h80, 1'b1);
        chk("asr_result", result, 8'hFF);
        chk("asr_carry", carry, 1'b0);
        chk("asr_busy_cycles", busy_n, 7);
        chk("asr_latency", lat, 8);

        run(2'd1, 3'd5, 8'h12, 1'b0);
        chk("ror5_result", result, 8'h90);
        chk("ror5_carry", carry, 1'b1);
`ifdef ALU_SHIFT_SWAP_SHORTCUT_EN
        chk("ror5_latency", lat, 3);
`else
        chk("ror5_latency", lat, 6);
`endif
        chk("ror5_outn", outn_bad, 0);

        run(2'd0, 3'd0, 8'h5A, 1'b1);
        chk("cnt0_latency", lat, 1);
        chk("cnt0_result", result, 8'h5A);
        chk("cnt0_carry", carry, 1'b1);
        chk("cnt0_busy", busy_n, 0);
        chk("cnt0_outn", outn_bad, 0);

        // Abort a count-5 LSR on its second RUN cycle
        @(negedge clk);
        mode = 2'd0; count = 3'd5; operand = 8'hFF; carry_init = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_was_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_result", result, 8'h00);
        chk("abort_carry", carry, 1'b0);
        chk("abort_ctl", {outn, fn_swap, busy, done}, 4'b1000);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        run(2'd1, 3'd1, 8'h81, 1'b0);
        chk("post_abort_result", result, 8'hC0);
        chk("post_abort_carry", carry, 1'b1);
        chk("post_abort_latency", lat, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
